dug_map: RTL and testbench

DUG_MAP -- requirements
Module: dug_map

---
 rtl/dug_map.sv | 142 ++++++++++++++
 tb/tb_dug_map.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dug_map.sv
// Dig map: 32x24 grid of 16x16-pixel cells below a 96-pixel header; tracks tunnelled cells.
// Optional start shaft (column 16, rows 0..11) set during INIT when DUG_MAP_PRESET_EN is defined.
//
// state    | meaning
// ST_INIT  | sweeping columns 0..31, clearing (and optionally presetting) the map
// ST_IDLE  | ready to accept a dig request
// ST_WRITE | one-cycle update of the registered dig point
module dug_map (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Restart,
  input  logic        Dig_valid,
  input  logic [9:0]  Dig_X,
  input  logic [9:0]  Dig_Y,
  output logic        Dig_ready,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [23:0] dug_state [31:0],
  output logic        is_dug,
  output logic [9:0]  Dug_count,
  output logic        Init_done
);

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [4:0] LAST_COL = 5'd31;

  logic [1:0]  state;
  logic [4:0]  col_idx;
  logic [9:0]  dig_x_q;
  logic [9:0]  dig_y_q;

  logic        accept;
  logic        wr_hit;
  logic [4:0]  wr_col;
  logic [4:0]  wr_row;
  logic        wr_bit_old;
  logic        pix_hit;
  logic [4:0]  pix_col;
  logic [4:0]  pix_row;
  logic [23:0] init_word;
  logic        init_sets_count;

  function automatic logic in_map(input logic [9:0] x, input logic [9:0] y);
    return (x < 10'd512) && (y >= 10'd96) && (y <= 10'd479);
  endfunction

  function automatic logic [4:0] col_of(input logic [9:0] x);
    return x[8:4];
  endfunction

  // Only meaningful when in_map() holds, so the subtract never wraps into a valid row.
  function automatic logic [4:0] row_of(input logic [9:0] y);
    logic [9:0] d;
    d = y - 10'd96;
    return d[8:4];
  endfunction

  assign Dig_ready = (state == ST_IDLE) && !Restart;
  assign accept    = Dig_valid && Dig_ready;
  assign Init_done = (state != ST_INIT);

  always_comb begin
    wr_hit     = in_map(dig_x_q, dig_y_q);
    wr_col     = col_of(dig_x_q);
    wr_row     = row_of(dig_y_q);
    wr_bit_old = 1'b0;
    if (wr_hit) begin
      wr_bit_old = dug_state[wr_col][wr_row];
    end
  end

  always_comb begin
    pix_hit = in_map(DrawX, DrawY);
    pix_col = col_of(DrawX);
    pix_row = row_of(DrawY);
    is_dug  = 1'b0;
    if (pix_hit) begin
      is_dug = dug_state[pix_col][pix_row];
    end
  end

`ifdef DUG_MAP_PRESET_EN
  assign init_word       = (col_idx == 5'd16) ? 24'h000FFF : 24'h000000;
  assign init_sets_count = (col_idx == 5'd16);
`else
  assign init_word       = 24'h000000;
  assign init_sets_count = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_INIT;
      col_idx   <= 5'd0;
      dig_x_q   <= 10'd0;
      dig_y_q   <= 10'd0;
      Dug_count <= 10'd0;
      for (int i = 0; i < 32; i++) begin
        dug_state[i] <= 24'h000000;
      end
    end else if (Restart) begin
      // Any pending write is dropped; the sweep rebuilds the map from column 0.
      state     <= ST_INIT;
      col_idx   <= 5'd0;
      Dug_count <= 10'd0;
    end else begin
      case (state)
        ST_INIT: begin
          dug_state[col_idx] <= init_word;
          if (init_sets_count) begin
            Dug_count <= 10'd12;
          end
          col_idx <= col_idx + 5'd1;
          if (col_idx == LAST_COL) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            dig_x_q <= Dig_X;
            dig_y_q <= Dig_Y;
            state   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (wr_hit && !wr_bit_old) begin
            dug_state[wr_col][wr_row] <= 1'b1;
            Dug_count <= Dug_count + 10'd1;
          end
          state <= ST_IDLE;
        end
        default: begin
          state   <= ST_INIT;
          col_idx <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dug_map.sv
// Bench for dug_map: directed boundary cases plus random digs against a cell-array model.
module tb_dug_map;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Restart = 1'b0;
  logic        Dig_valid = 1'b0;
  logic [9:0]  Dig_X = 10'd0;
  logic [9:0]  Dig_Y = 10'd0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic        Dig_ready;
  logic        is_dug;
  logic        Init_done;
  logic [9:0]  Dug_count;
  logic [23:0] dug_state [31:0];

  dug_map dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Restart   (Restart),
    .Dig_valid (Dig_valid),
    .Dig_X     (Dig_X),
    .Dig_Y     (Dig_Y),
    .Dig_ready (Dig_ready),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .dug_state (dug_state),
    .is_dug    (is_dug),
    .Dug_count (Dug_count),
    .Init_done (Init_done)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  bit [23:0] m_map [32];
  int        m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_in(input int x, input int y);
    return (x < 512) && (y >= 96) && (y <= 479);
  endfunction

  function automatic bit m_dug(input int x, input int y);
    if (!m_in(x, y)) return 1'b0;
    return m_map[x / 16][(y - 96) / 16];
  endfunction

  task automatic m_clear();
    for (int c = 0; c < 32; c++) m_map[c] = 24'h0;
    m_cnt = 0;
  endtask

  task automatic m_init();
    m_clear();
`ifdef DUG_MAP_PRESET_EN
    m_map[16] = 24'h000FFF;
    m_cnt = 12;
`endif
  endtask

  task automatic m_dig(input int x, input int y);
    if (m_in(x, y) && !m_map[x / 16][(y - 96) / 16]) begin
      m_map[x / 16][(y - 96) / 16] = 1'b1;
      m_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!Dig_ready && n < 100) begin
      check({tag, "_init_done_low"}, 32'(Init_done), 32'd0);
      tick();
      n++;
    end
    check({tag, "_init_cycles"}, 32'(n), 32'd32);
    check({tag, "_init_done_high"}, 32'(Init_done), 32'd1);
  endtask

  task automatic check_map(input string tag);
    for (int c = 0; c < 32; c++) begin
      check($sformatf("%s_col%0d", tag, c), 32'(dug_state[c]), 32'(m_map[c]));
    end
    check({tag, "_count"}, 32'(Dug_count), 32'(m_cnt));
  endtask

  task automatic dig(input int x, input int y, input string tag);
    Dig_X     = 10'(x);
    Dig_Y     = 10'(y);
    DrawX     = 10'(x);
    DrawY     = 10'(y);
    Dig_valid = 1'b1;
    #1;
    check({tag, "_ready_pre"}, 32'(Dig_ready), 32'd1);
    tick();
    Dig_valid = 1'b0;
    #1;
    check({tag, "_ready_write"}, 32'(Dig_ready), 32'd0);
    check({tag, "_is_dug_old"}, 32'(is_dug), 32'(m_dug(x, y)));
    tick();
    m_dig(x, y);
    check({tag, "_ready_post"}, 32'(Dig_ready), 32'd1);
    check({tag, "_is_dug_new"}, 32'(is_dug), 32'(m_dug(x, y)));
    check({tag, "_count"}, 32'(Dug_count), 32'(m_cnt));
  endtask

  task automatic probe(input int x, input int y, input string tag);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1;
    check(tag, 32'(is_dug), 32'(m_dug(x, y)));
  endtask

  initial begin
    m_clear();
    #12;
    check("rst_ready", 32'(Dig_ready), 32'd0);
    check("rst_init_done", 32'(Init_done), 32'd0);
    check("rst_count", 32'(Dug_count), 32'd0);
    check_map("rst_map");

    @(posedge Clk);
    #1;
    Reset = 1'b1;
    m_init();
    wait_init("por");
    check_map("por_map");
    probe(260, 100, "shaft_probe");

    dig(40, 130, "d40_130");
    check("cell_2_2", 32'(dug_state[2][2]), 32'd1);
    dig(40, 130, "d40_130_again");
    dig(600, 200, "d600_200");
    dig(40, 50, "d40_50");
    dig(511, 479, "d511_479");
    dig(0, 96, "d0_96");
    dig(0, 95, "d0_95");
    dig(512, 479, "d512_479");
    dig(100, 480, "d100_480");
    dig(1023, 1023, "dmax");
    check_map("dir_map");
    probe(40, 130, "probe_40_130");
    probe(40, 50, "probe_40_50");
    probe(511, 479, "probe_511_479");

    Restart = 1'b1;
    #1;
    check("ready_restart_idle", 32'(Dig_ready), 32'd0);
    Restart = 1'b0;
    #1;
    check("ready_after_restart_drop", 32'(Dig_ready), 32'd1);

    // Restart lands on the WRITE cycle of a fresh dig at column 12, row 12.
    Dig_X = 10'd200;
    Dig_Y = 10'd300;
    Dig_valid = 1'b1;
    tick();
    Dig_valid = 1'b0;
    Restart = 1'b1;
    tick();
    Restart = 1'b0;
    #1;
    m_init();
    check("restart_count", 32'(Dug_count), 32'd0);
    check("restart_ready", 32'(Dig_ready), 32'd0);
    wait_init("restart");
    check("restart_cell_12_12", 32'(dug_state[12][12]), 32'd0);
    check_map("restart_map");

    dig(300, 300, "pre_rst_dig");
    dig(20, 400, "pre_rst_dig2");
    Restart = 1'b1;
    tick();
    Restart = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    Reset = 1'b0;
    #1;
    m_clear();
    check("midinit_rst_init_done", 32'(Init_done), 32'd0);
    check_map("midinit_rst_map");
    #1;
    Reset = 1'b1;
    m_init();
    wait_init("midinit");
    check_map("midinit_map");

    for (int i = 0; i < 80; i++) begin
      dig(int'($urandom_range(0, 560)), int'($urandom_range(60, 500)), $sformatf("rnd%0d", i));
    end
    check_map("rnd_map");
    for (int i = 0; i < 40; i++) begin
      probe(int'($urandom_range(0, 1023)), int'($urandom_range(0, 600)), $sformatf("rnd_probe%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
